fifo_word_packer: RTL
=====================

# fifo_word_packer

Downstream drain stage for `Synchronous_FIFO`. Pops narrow WIDTH-bit entries from the FIFO read port and packs RATIO consecutive entries into one wide word. The wide word is presented on a valid/ready output. Partial words are emitted on an explicit flush request and, optionally, after an idle timeout.

## Interface
- `WIDTH`, 3: FIFO entry width in bits; must equal the FIFO's `width`.
- `RATIO`, 4: entries per packed output word; must be ≥ 2.
- `TIMEOUT`, 8: idle cycles before an automatic partial flush; only used with `FIFO_PACKER_TIMEOUT_EN`; must be ≥ 1.

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_data` in WIDTH: FIFO `data_out`.
- `fifo_read_en` out 1: FIFO `read_en`.
- `flush` in 1: single-cycle request to emit the current partial word.
- `out_data` out WIDTH*RATIO: packed word.
  - First-popped entry sits in bits [WIDTH-1:0]; lane k sits in bits [(k+1)*WIDTH-1 : k*WIDTH].
  - Unfilled lanes read 0.
- `out_count` out clog2(RATIO+1): number of valid lanes in `out_data`, from 1 to RATIO.
- `out_valid` out 1: `out_data`/`out_count` are valid.
- `out_ready` in 1: consumer accepts the word.

## Operation
- **FIFO read contract:** `fifo_data` is valid one cycle after a cycle in which `fifo_read_en`=1 and `fifo_empty`=0.
- **Internal state:**
  - `state` ∈ {COLLECT, HOLD}.
  - `fill`: number of lanes captured, 0..RATIO.
  - `pend`: 1-bit flag; a read is in flight (registered copy of `fifo_read_en`).
  - `flush_req`: sticky flag.
  - Lane registers.
- **Read issue (combinational):** `fifo_read_en` = (state==COLLECT) && !fifo_empty && (fill+pend < RATIO) && !flush_req. Back-to-back reads are allowed.
- **Capture:** when `pend`=1, lane[fill] ← `fifo_data` and `fill` increments.
- **COLLECT → HOLD:**
  - When `fill` reaches RATIO; or
  - When `flush_req`=1, `pend`=0 and `fill`>0. Word is emitted with `out_count`=fill and `flush_req` is cleared.
- **Empty flush:** `flush_req` with `fill`=0 and `pend`=0 clears `flush_req` and emits nothing.
- **Flush registration:**
  - `flush`=1 in any state sets `flush_req`.
  - In HOLD it applies to the next word.
  - An in-flight read always completes into its lane before the flush takes effect.
- **HOLD:**
  - `out_valid`=1; `out_data` and `out_count` are stable.
  - `fifo_read_en`=0.
  - On `out_valid && out_ready`: fill, lanes and `out_count` clear; state → COLLECT.
- **Reset (asynchronous, any time, including mid-HOLD or with a read in flight):**
  - state=COLLECT; fill=0; pend=0; flush_req=0; lanes=0; idle counter=0.
  - Outputs: `out_valid`=0, `out_data`=0, `out_count`=0, `fifo_read_en`=0.
  - A FIFO read in flight at reset is dropped.

## Timing
- **Full word latency:** with the FIFO continuously non-empty and first `fifo_read_en` in cycle N:
  - Reads occur in cycles N..N+RATIO-1.
  - `out_valid` rises in cycle N+RATIO.
- **Minimum period:** RATIO+1 cycles per word (HOLD lasts at least one cycle).
- **Flush latency:** `flush` in cycle F with no read in flight → `out_valid` in cycle F+2. One cycle later if a read is in flight.
- **Backpressure:** `out_valid` never deasserts without a handshake, except on reset.
- **Simultaneous events:**
  - Capture of the RATIO-th entry with `flush` in the same cycle: full word emitted (`out_count`=RATIO); `flush_req` stays set for the following word.
  - `fifo_empty` deasserting in the handshake cycle: first read is issued the next cycle.

## Configuration
- **Macro:** `FIFO_PACKER_TIMEOUT_EN`.
- **Defined:**
  - Idle counter increments each COLLECT cycle with fill>0, pend=0 and `fifo_read_en`=0.
  - It resets to 0 on any read or on leaving COLLECT.
  - On reaching TIMEOUT it sets `flush_req`.
- **Undefined:** no counter logic; partial words leave only via `flush`.

## Test plan
- **Full word:** WIDTH=3, RATIO=4; FIFO holds 1,2,3,4; `out_ready`=1 → single word with `out_data`=12'h8D1, `out_count`=4, `out_valid` 4 cycles after first `fifo_read_en`.
- **Backpressure:** word ready, `out_ready`=0 for 5 cycles, FIFO holds further entries → `out_valid`, `out_data` stable and `fifo_read_en`=0 throughout; accepted on cycle 6.
- **Partial flush:** push 5,6; pulse `flush` → `out_data`=12'h035, `out_count`=2. A second `flush` with fill=0 → no `out_valid`.
- **Timeout:** push 7, then FIFO empty.
  - Defined: `out_valid` with `out_data`=12'h007, `out_count`=1 after 8 idle cycles.
  - Undefined: no output for 100 cycles.
- **Reset mid-operation:** assert `rst_n`=0 in HOLD and again with a read in flight → `out_valid`=0 immediately (asynchronous); next word after release starts at lane 0.
- **Empty boundary:** `fifo_empty`=1 for 20 cycles → `fifo_read_en` never asserted; fill stays 0.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Packs RATIO consecutive WIDTH-bit FIFO entries into one wide valid/ready word.
// Define FIFO_PACKER_TIMEOUT_EN to emit partial words after TIMEOUT idle cycles.
module fifo_word_packer #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned RATIO   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   fifo_empty,
  input  logic [WIDTH-1:0]                       fifo_data,
  output logic                                   fifo_read_en,
  input  logic                                   flush,
  output logic [WIDTH*RATIO-1:0]                 out_data,
  output logic [$clog2(RATIO+1)-1:0]             out_count,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int unsigned OW = WIDTH * RATIO;
  localparam int unsigned CW = $clog2(RATIO + 1);

  if (RATIO < 2) begin : g_bad_ratio
    $error("fifo_word_packer: RATIO must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_word_packer: TIMEOUT must be at least 1");
  end

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                        state;
  logic [CW-1:0]                 fill;
  logic                          pend;
  logic                          flush_req;
  logic [RATIO-1:0][WIDTH-1:0]   lanes;
  logic [CW-1:0]                 count_q;

  logic rd_c;
  logic last_c;
  logic timeout_hit_c;
  logic flush_set_c;

  // Read issue; held low during reset so no read is started while the block is cleared.
  assign rd_c = rst_n && (state == COLLECT) && !fifo_empty && !flush_req &&
                ((32'(fill) + 32'(pend)) < RATIO);

  // Final lane arriving this cycle: the word is presented straight from fifo_data.
  assign last_c = (state == COLLECT) && pend && (32'(fill) == (RATIO - 1));

  assign flush_set_c  = flush || timeout_hit_c;
  assign fifo_read_en = rd_c;
  assign out_valid    = (state == HOLD) || last_c;
  assign out_count    = last_c ? CW'(RATIO) : count_q;

  always_comb begin
    out_data = lanes;
    if (last_c) out_data[OW-1 -: WIDTH] = fifo_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      fill      <= '0;
      pend      <= 1'b0;
      flush_req <= 1'b0;
      lanes     <= '0;
      count_q   <= '0;
    end else begin
      pend <= rd_c;
      if (flush_set_c) flush_req <= 1'b1;
      case (state)
        COLLECT: begin
          if (pend) begin
            for (int k = 0; k < RATIO; k++) begin
              if (fill == CW'(k)) lanes[k] <= fifo_data;
            end
            if (last_c) begin
              if (out_ready) begin
                fill    <= '0;
                lanes   <= '0;
                count_q <= '0;
              end else begin
                fill    <= fill + CW'(1);
                count_q <= CW'(RATIO);
                state   <= HOLD;
              end
            end else begin
              fill <= fill + CW'(1);
            end
          end else if (flush_req) begin
            // Partial word leaves only once no read is outstanding; empty flush just clears.
            if (fill != '0) begin
              count_q <= fill;
              state   <= HOLD;
            end
            flush_req <= flush_set_c;
          end
        end
        HOLD: begin
          if (out_ready) begin
            fill    <= '0;
            lanes   <= '0;
            count_q <= '0;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef FIFO_PACKER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_cnt;
  logic          idle_inc_c;

  assign idle_inc_c    = (state == COLLECT) && (fill != '0) && !pend && !rd_c;
  assign timeout_hit_c = idle_inc_c && ((32'(idle_cnt) + 32'd1) >= TIMEOUT);

  // Idle counter restarts on any read, on leaving COLLECT and when it fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != COLLECT) || rd_c || timeout_hit_c) begin
      idle_cnt <= '0;
    end else if (idle_inc_c) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit_c = 1'b0;
`endif

endmodule
